// File: rtl/key_event_ctrl.sv
// Purpose : turns a debounced key level into one-cycle short / double / long / repeat event pulses.
// Latency : 1 cycle from key_filter to any event pulse or key_busy change; all outputs registered.
// Backpr. : none; events are fire-and-forget pulses and the consumer must sample them every cycle.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   key_filter  debounced key level (ACTIVE_LEVEL means pressed)
//   enable      1 = classify events, 0 = hold the sequencer in IDLE
//   evt_short   pulse: single short press completed (release gap expired)
//   evt_double  pulse: second press of a double click released
//   evt_long    pulse: hold reached LONG_TIME cycles
//   evt_repeat  pulse: every REPEAT_TIME cycles while still held after evt_long
//   key_busy    1 while the sequencer is not in IDLE
module key_event_ctrl #(
    parameter logic             ACTIVE_LEVEL = 1'b0,
    parameter int               CNT_W        = 32,
    parameter logic [CNT_W-1:0] LONG_TIME    = CNT_W'(50_000_000),
    parameter logic [CNT_W-1:0] DCLICK_GAP   = CNT_W'(12_500_000),
    parameter logic [CNT_W-1:0] REPEAT_TIME  = CNT_W'(5_000_000)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_filter,
    input  logic enable,
    output logic evt_short,
    output logic evt_double,
    output logic evt_long,
    output logic evt_repeat,
    output logic key_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    // Timeouts fire on the cycle the counter shows TIME-1, so the event lands
    // exactly TIME edges after the state was entered.
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_TIME - CNT_ONE;
    localparam logic [CNT_W-1:0] GAP_LAST  = DCLICK_GAP - CNT_ONE;
    localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_TIME - CNT_ONE;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             key_q;
    logic             pressed;
    logic             press_edge;
    logic             release_edge;
    logic             short_nxt;
    logic             double_nxt;
    logic             long_nxt;
    logic             repeat_nxt;

    // Edge detection runs in the "pressed" domain so ACTIVE_LEVEL only
    // matters here.
    assign pressed      = (key_filter == ACTIVE_LEVEL);
    assign press_edge   = pressed & ~key_q;
    assign release_edge = ~pressed & key_q;

    // Saturating increment: a stuck key cannot wrap the counter back into a
    // timeout match.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Next-state / next-event logic. Every transition leaves cnt_nxt at its
    // default of zero; only the stay-in-state branches advance it. Edge tests
    // come before timeout tests so a key edge always wins a tie.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = '0;
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (press_edge) begin
                        state_nxt = PRESS1;
                    end
                end

                PRESS1: begin
                    if (release_edge) begin
                        state_nxt = WAIT2;
                    end else if (cnt == LONG_LAST) begin
                        state_nxt = LONG;
                        long_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end

                WAIT2: begin
                    if (press_edge) begin
                        state_nxt = PRESS2;
                    end else if (cnt == GAP_LAST) begin
                        state_nxt = IDLE;
                        short_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end

                // A long hold on the second press is deliberately not timed:
                // the gesture is already committed to a double click.
                PRESS2: begin
                    if (release_edge) begin
                        state_nxt  = IDLE;
                        double_nxt = 1'b1;
                    end
                end

                LONG: begin
                    if (release_edge) begin
                        state_nxt = IDLE;
                    end else if (cnt == REP_LAST) begin
                        repeat_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register plus registered outputs. key_q resets to "pressed" so a
    // key held through reset produces no press edge until it is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            key_q      <= 1'b1;
            evt_short  <= 1'b0;
            evt_double <= 1'b0;
            evt_long   <= 1'b0;
            evt_repeat <= 1'b0;
            key_busy   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            key_q      <= pressed;
            evt_short  <= short_nxt;
            evt_double <= double_nxt;
            evt_long   <= long_nxt;
            evt_repeat <= repeat_nxt;
            key_busy   <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with short timing constants.
// Stimulus is driven just after the falling edge; outputs are sampled on the
// falling edge, so every recorded event is tagged with the rising edge that
// produced it.
module tb_key_event_ctrl;

    logic clk;
    logic rst_n;
    logic key_filter;
    logic enable;
    logic evt_short;
    logic evt_double;
    logic evt_long;
    logic evt_repeat;
    logic key_busy;

    int n_tests;
    int n_fail;

    // rising-edge counter and event monitor state
    int edge_n;
    int n_short, n_double, n_long, n_rep, n_multi;
    int t_short, t_double, t_long, t_rep_first, t_rep_last;

    key_event_ctrl #(
        .ACTIVE_LEVEL (1'b0),
        .CNT_W        (32),
        .LONG_TIME    (32'd20),
        .DCLICK_GAP   (32'd8),
        .REPEAT_TIME  (32'd5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_filter (key_filter),
        .enable     (enable),
        .evt_short  (evt_short),
        .evt_double (evt_double),
        .evt_long   (evt_long),
        .evt_repeat (evt_repeat),
        .key_busy   (key_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_n = 0;
    always @(posedge clk) edge_n = edge_n + 1;

    always @(negedge clk) begin
        if ((int'(evt_short) + int'(evt_double) + int'(evt_long) + int'(evt_repeat)) > 1)
            n_multi = n_multi + 1;
        if (evt_short) begin
            n_short = n_short + 1;
            t_short = edge_n;
        end
        if (evt_double) begin
            n_double = n_double + 1;
            t_double = edge_n;
        end
        if (evt_long) begin
            n_long = n_long + 1;
            t_long = edge_n;
        end
        if (evt_repeat) begin
            if (n_rep == 0) t_rep_first = edge_n;
            t_rep_last = edge_n;
            n_rep = n_rep + 1;
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_mon();
        n_short = 0; n_double = 0; n_long = 0; n_rep = 0; n_multi = 0;
        t_short = -1; t_double = -1; t_long = -1; t_rep_first = -1; t_rep_last = -1;
    endtask

    int t0;
    int r;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr_mon();
        rst_n      = 1'b0;
        key_filter = 1'b1;
        enable     = 1'b1;

        // ---- reset state
        tick(3);
        check("reset_outputs", int'({evt_short, evt_double, evt_long, evt_repeat, key_busy}), 0);
        rst_n = 1'b1;
        tick(3);
        check("idle_busy", int'(key_busy), 0);

        // ---- 1: short press, 5 cycles low
        clr_mon();
        key_filter = 1'b0; t0 = edge_n + 1;
        tick(1);
        check("short_busy_on", int'(key_busy), 1);
        tick(4);
        key_filter = 1'b1;
        tick(15);
        check("short_count", n_short, 1);
        check("short_time", t_short - t0, 13);
        check("short_other", n_double + n_long + n_rep, 0);
        check("short_busy_off", int'(key_busy), 0);

        // ---- 2: double click, press 3 / release 3 / press 2
        clr_mon();
        key_filter = 1'b0; t0 = edge_n + 1;
        tick(3);
        key_filter = 1'b1;
        tick(3);
        key_filter = 1'b0;
        tick(2);
        key_filter = 1'b1;
        tick(15);
        check("dbl_count", n_double, 1);
        check("dbl_time", t_double - t0, 8);
        check("dbl_no_short", n_short, 0);
        check("dbl_busy_off", int'(key_busy), 0);

        // ---- 3: long hold 38 cycles
        clr_mon();
        key_filter = 1'b0; t0 = edge_n + 1;
        tick(38);
        key_filter = 1'b1;
        tick(12);
        check("long_count", n_long, 1);
        check("long_time", t_long - t0, 20);
        check("rep_count", n_rep, 3);
        check("rep_first", t_rep_first - t0, 25);
        check("rep_last", t_rep_last - t0, 35);
        check("long_no_short", n_short + n_double, 0);
        check("long_busy_off", int'(key_busy), 0);

        // ---- 4: ties, release at cnt==19, second press at cnt==7
        clr_mon();
        key_filter = 1'b0; t0 = edge_n + 1;
        tick(20);
        key_filter = 1'b1;
        tick(8);
        key_filter = 1'b0;
        tick(2);
        key_filter = 1'b1;
        tick(12);
        check("tie_no_long", n_long + n_rep, 0);
        check("tie_no_short", n_short, 0);
        check("tie_double", n_double, 1);
        check("tie_dbl_time", t_double - t0, 30);

        // ---- 5: key held through reset
        clr_mon();
        key_filter = 1'b0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        check("held_rst_events", n_short + n_double + n_long + n_rep, 0);
        check("held_rst_busy", int'(key_busy), 0);
        key_filter = 1'b1;
        tick(3);
        key_filter = 1'b0;
        tick(2);
        key_filter = 1'b1; r = edge_n + 1;
        tick(12);
        check("held_rst_short", n_short, 1);
        check("held_rst_time", t_short - r, 8);

        // ---- 6a: enable dropped mid-WAIT2
        clr_mon();
        key_filter = 1'b0;
        tick(3);
        key_filter = 1'b1;
        tick(3);
        check("en_wait2_busy", int'(key_busy), 1);
        enable = 1'b0;
        tick(1);
        check("en_drop_busy", int'(key_busy), 0);
        enable = 1'b1;
        tick(15);
        check("en_no_short", n_short, 0);
        check("en_busy_end", int'(key_busy), 0);

        // ---- 6b: reset pulsed mid-WAIT2
        clr_mon();
        key_filter = 1'b0;
        tick(3);
        key_filter = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("rst_drop_busy", int'(key_busy), 0);
        rst_n = 1'b1;
        tick(15);
        check("rst_no_events", n_short + n_double + n_long + n_rep, 0);
        check("rst_busy_end", int'(key_busy), 0);

        check("one_hot_events", n_multi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
